// File: rtl/tm_feedback_engine_if.sv
// Tsetlin-machine feedback engine bus.
// Carries the request (start, clause context, literals, thresholds, weight,
// seed), the external state-RAM read/write port and the status/result lines.
//   master : request side plus the RAM data return (bench / host)
//   slave  : the engine
interface tm_feedback_engine_if #(
  parameter int LITERAL_NUM  = 272,
  parameter int LANES        = 16,
  parameter int STATE_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int RAND_WIDTH   = 16
);
  localparam int CHUNKS = LITERAL_NUM / LANES;
  localparam int AW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  logic                         start;
  logic                         is_positive;
  logic                         clause_out;
  logic [LITERAL_NUM-1:0]       literals;
  logic [RAND_WIDTH:0]          s_thresh;
  logic [WEIGHT_WIDTH-1:0]      weight_in;
  logic                         seed_load;
  logic [RAND_WIDTH-1:0]        seed;
  logic                         rd_en;
  logic [AW-1:0]                rd_addr;
  logic [LANES*STATE_WIDTH-1:0] rd_data;
  logic                         wr_en;
  logic [AW-1:0]                wr_addr;
  logic [LANES*STATE_WIDTH-1:0] wr_data;
  logic                         busy;
  logic                         done;
  logic [WEIGHT_WIDTH-1:0]      weight_out;

  modport master (
    output start, is_positive, clause_out, literals, s_thresh, weight_in,
           seed_load, seed, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, weight_out
  );

  modport slave (
    input  start, is_positive, clause_out, literals, s_thresh, weight_in,
           seed_load, seed, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, weight_out
  );
endinterface

// File: rtl/tm_feedback_engine.sv
// Tsetlin-machine clause feedback engine.
// Streams the clause's TA states chunk by chunk (LANES TAs per chunk) from an
// external RAM, applies Type I / Type II feedback per TA and writes each
// updated chunk back in the cycle its read data returns. Also produces the
// updated clause weight.
// Ports: clk, rst_n (async active-low), bus (tm_feedback_engine_if.slave):
//   request  : start, is_positive, clause_out, literals, s_thresh, weight_in
//   seeding  : seed_load, seed (honoured only while idle)
//   RAM      : rd_en/rd_addr/rd_data (1-cycle latency), wr_en/wr_addr/wr_data
//   status   : busy, done (1-cycle pulse), weight_out

// One TA lane: private LFSR plus the state update rule.
module tm_fb_lane #(
  parameter int STATE_WIDTH = 8,
  parameter int RAND_WIDTH  = 16,
  parameter int LANE_ID     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   seed_load,
  input  logic [RAND_WIDTH-1:0]  seed,
  input  logic                   adv,
  input  logic                   is_pos,
  input  logic                   clause,
  input  logic                   lit,
  input  logic [RAND_WIDTH:0]    s_thresh,
  input  logic [STATE_WIDTH-1:0] st_in,
  output logic [STATE_WIDTH-1:0] st_out
);
  localparam logic [RAND_WIDTH-1:0] ID1 = RAND_WIDTH'(LANE_ID + 1);
  // Fibonacci feedback taps for common widths; fallback uses the top two bits.
  localparam logic [RAND_WIDTH-1:0] TAPS =
    (RAND_WIDTH == 16) ? RAND_WIDTH'(32'h0000_B400) :
    (RAND_WIDTH == 8)  ? RAND_WIDTH'(32'h0000_00B8) :
    (RAND_WIDTH == 32) ? RAND_WIDTH'(32'h8020_0003) :
                         (RAND_WIDTH'(3) << (RAND_WIDTH - 2));
  localparam logic [STATE_WIDTH-1:0] SMAX = '1;

  logic [RAND_WIDTH-1:0] lfsr, seeded;
  logic fb, lo, inc, dec;

  assign seeded = seed ^ ID1;
  assign fb     = ^(lfsr & TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         lfsr <= ID1;
    else if (seed_load) lfsr <= (seeded == '0) ? RAND_WIDTH'(1) : seeded;
    else if (adv)       lfsr <= {lfsr[RAND_WIDTH-2:0], fb};
  end

  // Widened compare so s_thresh = 2^RAND_WIDTH means "always".
  assign lo = ({1'b0, lfsr} < s_thresh);

  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    if (is_pos) begin
      if (clause && lit) inc = !lo;
      else               dec = lo;
    end else begin
      // Type II only pushes excluded TAs of a false literal toward include.
      inc = clause && !lit && !st_in[STATE_WIDTH-1];
    end
    st_out = st_in;
    if (inc && st_in != SMAX)     st_out = st_in + STATE_WIDTH'(1);
    else if (dec && st_in != '0)  st_out = st_in - STATE_WIDTH'(1);
  end
endmodule

module tm_feedback_engine #(
  parameter int LITERAL_NUM  = 272,
  parameter int LANES        = 16,
  parameter int STATE_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int RAND_WIDTH   = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  tm_feedback_engine_if.slave bus
);
  localparam int CHUNKS = LITERAL_NUM / LANES;
  localparam int AW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [WEIGHT_WIDTH-1:0] WMAX = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
  localparam logic [WEIGHT_WIDTH-1:0] WMIN = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};

  if (LITERAL_NUM % LANES != 0) begin : g_bad_cfg
    $error("LITERAL_NUM must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                    is_pos;
    logic                    clause;
    logic [RAND_WIDTH:0]     s_thresh;
    logic [WEIGHT_WIDTH-1:0] weight;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q;
  logic [CHUNKS-1:0][LANES-1:0]      lit_q;
  logic [AW-1:0]                     rd_addr_q, wr_addr_q;
  logic                              vld_q;     // read data returning this cycle
  logic [WEIGHT_WIDTH-1:0]           w_next, weight_out_q;
  logic [LANES-1:0][STATE_WIDTH-1:0] rd_lanes, upd_lanes;
  logic accept, last_rd, seed_ok;

  assign accept  = (state_q == IDLE) && bus.start;
  assign last_rd = (rd_addr_q == AW'(CHUNKS - 1));
  assign seed_ok = (state_q == IDLE) && bus.seed_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_rd)   state_d = DRAIN;
      DRAIN:   state_d = DONE;   // last chunk's write happens here
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q        <= '0;
      lit_q        <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      vld_q        <= 1'b0;
      weight_out_q <= '0;
    end else begin
      if (accept) begin
        req_q <= '{is_pos: bus.is_positive, clause: bus.clause_out,
                   s_thresh: bus.s_thresh, weight: bus.weight_in};
        lit_q <= bus.literals;
      end
      vld_q <= (state_q == RUN);
      if (state_q == RUN) begin
        rd_addr_q <= last_rd ? '0 : rd_addr_q + AW'(1);
        wr_addr_q <= rd_addr_q;
      end
      if (state_q == DRAIN) weight_out_q <= w_next;
    end
  end

  // Weight: Type I grows magnitude (sign from weight_in, >=0 is positive),
  // Type II shrinks it toward zero; only when the clause fired.
  always_comb begin
    w_next = req_q.weight;
    if (req_q.clause) begin
      if (req_q.is_pos) begin
        if (!req_q.weight[WEIGHT_WIDTH-1]) begin
          if (req_q.weight != WMAX) w_next = req_q.weight + WEIGHT_WIDTH'(1);
        end else if (req_q.weight != WMIN) begin
          w_next = req_q.weight - WEIGHT_WIDTH'(1);
        end
      end else begin
        if (req_q.weight[WEIGHT_WIDTH-1])  w_next = req_q.weight + WEIGHT_WIDTH'(1);
        else if (req_q.weight != '0)       w_next = req_q.weight - WEIGHT_WIDTH'(1);
      end
    end
  end

  assign rd_lanes = bus.rd_data;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    tm_fb_lane #(
      .STATE_WIDTH(STATE_WIDTH),
      .RAND_WIDTH (RAND_WIDTH),
      .LANE_ID    (j)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .seed_load(seed_ok),
      .seed     (bus.seed),
      .adv      (vld_q),
      .is_pos   (req_q.is_pos),
      .clause   (req_q.clause),
      .lit      (lit_q[wr_addr_q][j]),
      .s_thresh (req_q.s_thresh),
      .st_in    (rd_lanes[j]),
      .st_out   (upd_lanes[j])
    );
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.rd_en      = (state_q == RUN);
  assign bus.rd_addr    = rd_addr_q;
  assign bus.wr_en      = vld_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = vld_q ? upd_lanes : '0;
  assign bus.weight_out = weight_out_q;
endmodule

// File: tb/tb_tm_feedback_engine.sv
module tb_tm_feedback_engine;
  localparam int LN     = 272;
  localparam int LANES  = 16;
  localparam int SW     = 8;
  localparam int WW     = 8;
  localparam int RW     = 16;
  localparam int CHUNKS = LN / LANES;
  localparam int SMAXI  = (1 << SW) - 1;
  localparam int WMAXI  = (1 << (WW - 1)) - 1;
  localparam int WMINI  = -(1 << (WW - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tm_feedback_engine_if #(.LITERAL_NUM(LN), .LANES(LANES), .STATE_WIDTH(SW),
                          .WEIGHT_WIDTH(WW), .RAND_WIDTH(RW)) bus ();

  tm_feedback_engine #(.LITERAL_NUM(LN), .LANES(LANES), .STATE_WIDTH(SW),
                       .WEIGHT_WIDTH(WW), .RAND_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // External state RAM, 1-cycle read latency.
  logic [LANES*SW-1:0] ram [CHUNKS];
  logic [LANES*SW-1:0] img [CHUNKS];
  logic load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int c = 0; c < CHUNKS; c++) ram[c] <= img[c];
    end else if (bus.wr_en) begin
      ram[bus.wr_addr] <= bus.wr_data;
    end
    if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
  end

  int tests = 0;
  int fails = 0;
  int mst [LN];                 // expected TA states
  logic [RW-1:0] mlfsr [LANES]; // expected lane random values

  function automatic logic [RW-1:0] lfsr_step(input logic [RW-1:0] v);
    return {v[RW-2:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int ram_state(input int i);
    logic [LANES*SW-1:0] row;
    row = ram[i / LANES];
    return int'(row[(i % LANES)*SW +: SW]);
  endfunction

  function automatic int ram_bad();
    int n = 0;
    for (int i = 0; i < LN; i++) if (ram_state(i) != mst[i]) n++;
    return n;
  endfunction

  function automatic int exp_weight(input bit pos, input bit clause, input int w);
    if (!clause) return w;
    if (pos) return (w >= 0) ? ((w < WMAXI) ? w + 1 : w) : ((w > WMINI) ? w - 1 : w);
    return (w > 0) ? w - 1 : ((w < 0) ? w + 1 : 0);
  endfunction

  // Reference: every literal sees its lane's random value for its chunk index.
  task automatic model_op(input bit pos, input bit clause, input logic [LN-1:0] lits,
                          input logic [RW:0] st);
    for (int c = 0; c < CHUNKS; c++) begin
      for (int j = 0; j < LANES; j++) begin
        int i = c * LANES + j;
        bit lo = ({1'b0, mlfsr[j]} < st);
        int s = mst[i];
        if (pos) begin
          if (clause && lits[i]) begin if (!lo) s = s + 1; end
          else if (lo) s = s - 1;
        end else if (clause && !lits[i] && s < (1 << (SW - 1))) begin
          s = s + 1;
        end
        if (s < 0) s = 0;
        if (s > SMAXI) s = SMAXI;
        mst[i] = s;
      end
      for (int j = 0; j < LANES; j++) mlfsr[j] = lfsr_step(mlfsr[j]);
    end
  endtask

  task automatic sync_img();
    for (int c = 0; c < CHUNKS; c++)
      for (int j = 0; j < LANES; j++)
        img[c][j*SW +: SW] = SW'(mst[c*LANES + j]);
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic reset_lfsr_model();
    for (int j = 0; j < LANES; j++) mlfsr[j] = RW'(j + 1);
  endtask

  task automatic run_op(input bit pos, input bit clause, input logic [LN-1:0] lits,
                        input logic [RW:0] st, input int w, input bit hold,
                        output int dcyc, output int dcnt, output int wout);
    @(negedge clk);
    bus.is_positive = pos;
    bus.clause_out  = clause;
    bus.literals    = lits;
    bus.s_thresh    = st;
    bus.weight_in   = WW'(w);
    bus.start       = 1'b1;
    dcyc = -1; dcnt = 0; wout = 0;
    for (int cyc = 1; cyc <= CHUNKS + 8; cyc++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (hold && cyc == 1) begin
        bus.seed_load = 1'b1;
        bus.seed      = RW'($urandom);
      end
      if (bus.done) begin
        if (dcnt == 0) begin
          dcyc = cyc;
          wout = int'($signed(bus.weight_out));
        end
        dcnt++;
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
      end
    end
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
  endtask

  task automatic test_reset();
    int wr_seen = 0;
    bus.start = 0; bus.is_positive = 0; bus.clause_out = 0; bus.literals = '0;
    bus.s_thresh = '0; bus.weight_in = '0; bus.seed_load = 0; bus.seed = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.rd_addr, bus.wr_addr,
         bus.wr_data, bus.weight_out} !== '0) begin
      fails++;
      $display("FAIL reset_outputs busy=%b done=%b rd_en=%b wr_en=%b wdata=%h wout=%h exp all 0",
               bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.wr_data, bus.weight_out);
    end
    rst_n = 1'b1;
    reset_lfsr_model();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.wr_en) wr_seen++;
    end
    tests++;
    if (wr_seen != 0) begin
      fails++;
      $display("FAIL idle_no_write wr_en cycles=%0d exp 0", wr_seen);
    end
  endtask

  task automatic test_type1_inc();
    int dcyc, dcnt, wout;
    for (int i = 0; i < LN; i++) mst[i] = 10;
    mst[5] = 255; mst[LN-1] = 255;
    sync_img();
    run_op(1, 1, '1, '0, 127, 0, dcyc, dcnt, wout);
    model_op(1, 1, '1, '0);
    tests++;
    if (ram_state(0) != 11 || ram_state(100) != 11 || ram_state(5) != 255 || ram_state(LN-1) != 255) begin
      fails++;
      $display("FAIL t1_inc states got %0d/%0d/%0d/%0d exp 11/11/255/255",
               ram_state(0), ram_state(100), ram_state(5), ram_state(LN-1));
    end
    tests++;
    if (ram_bad() != 0) begin fails++; $display("FAIL t1_inc_all bad=%0d exp 0", ram_bad()); end
    tests++;
    if (dcyc != CHUNKS + 2 || dcnt != 1) begin
      fails++;
      $display("FAIL t1_done_timing cycle=%0d count=%0d exp %0d/1", dcyc, dcnt, CHUNKS + 2);
    end
    tests++;
    if (wout != 127) begin fails++; $display("FAIL t1_weight_sat got %0d exp 127", wout); end
  endtask

  task automatic test_type2();
    int dcyc, dcnt, wout, bad;
    for (int i = 0; i < LN; i++) mst[i] = (i % 2 == 0) ? 127 : 128;
    sync_img();
    run_op(0, 1, '0, 17'($urandom_range(0, 65536)), -3, 0, dcyc, dcnt, wout);
    model_op(0, 1, '0, '0);
    bad = 0;
    for (int i = 0; i < LN; i++) if (ram_state(i) != 128) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL t2_lit0 states!=128 count=%0d exp 0", bad); end
    tests++;
    if (wout != -2 || dcnt != 1) begin
      fails++; $display("FAIL t2_weight_neg got %0d (done x%0d) exp -2", wout, dcnt);
    end
    for (int i = 0; i < LN; i++) mst[i] = 127;
    sync_img();
    run_op(0, 1, '1, '0, 0, 0, dcyc, dcnt, wout);
    model_op(0, 1, '1, '0);
    bad = 0;
    for (int i = 0; i < LN; i++) if (ram_state(i) != 127) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL t2_lit1 states!=127 count=%0d exp 0", bad); end
    tests++;
    if (wout != 0) begin fails++; $display("FAIL t2_weight_zero got %0d exp 0", wout); end
  endtask

  task automatic test_clause0();
    int dcyc, dcnt, wout, bad, w;
    logic [LN-1:0] lits;
    for (int i = 0; i < LN; i++) lits[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < LN; i++) mst[i] = (i % 3 == 0) ? 0 : 5;
    sync_img();
    w = $urandom_range(0, 255) - 128;
    run_op(1, 0, lits, 17'h10000, w, 0, dcyc, dcnt, wout);
    model_op(1, 0, lits, 17'h10000);
    bad = 0;
    for (int i = 0; i < LN; i++) if (ram_state(i) != ((i % 3 == 0) ? 0 : 4)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL c0_always_dec wrong=%0d exp 0", bad); end
    tests++;
    if (wout != w) begin fails++; $display("FAIL c0_weight got %0d exp %0d", wout, w); end
    run_op(1, 0, lits, '0, w, 0, dcyc, dcnt, wout);
    model_op(1, 0, lits, '0);
    bad = 0;
    for (int i = 0; i < LN; i++) if (ram_state(i) != ((i % 3 == 0) ? 0 : 4)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL c0_never_dec changed=%0d exp 0", bad); end
  endtask

  task automatic test_weights();
    int dcyc, dcnt, wout;
    run_op(1, 1, '1, '0, -3, 0, dcyc, dcnt, wout);
    model_op(1, 1, '1, '0);
    tests++;
    if (wout != -4) begin fails++; $display("FAIL w_t1_neg got %0d exp -4", wout); end
    run_op(1, 1, '1, '0, -128, 0, dcyc, dcnt, wout);
    model_op(1, 1, '1, '0);
    tests++;
    if (wout != -128) begin fails++; $display("FAIL w_t1_min got %0d exp -128", wout); end
    tests++;
    if (ram_bad() != 0) begin fails++; $display("FAIL w_states bad=%0d exp 0", ram_bad()); end
  endtask

  // start and seed_load are held high across the whole operation.
  task automatic test_back_to_back();
    int dcyc, dcnt, wout;
    logic [LN-1:0] lits;
    for (int i = 0; i < LN; i++) begin
      lits[i] = 1'($urandom_range(0, 1));
      mst[i]  = $urandom_range(0, SMAXI);
    end
    sync_img();
    run_op(1, 1, lits, 17'h8000, 20, 1, dcyc, dcnt, wout);
    model_op(1, 1, lits, 17'h8000);
    tests++;
    if (dcnt != 1 || dcyc != CHUNKS + 2) begin
      fails++; $display("FAIL hs_done count=%0d cycle=%0d exp 1/%0d", dcnt, dcyc, CHUNKS + 2);
    end
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL hs_idle busy=%b exp 0", bus.busy); end
    tests++;
    if (ram_bad() != 0) begin fails++; $display("FAIL hs_states bad=%0d exp 0", ram_bad()); end
  endtask

  task automatic test_reset_midop();
    int wr_seen = 0, done_seen = 0, waited = 0;
    for (int i = 0; i < LN; i++) mst[i] = 50;
    sync_img();
    @(negedge clk);
    bus.is_positive = 1; bus.clause_out = 1; bus.literals = '1;
    bus.s_thresh = '0; bus.weight_in = '0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!(bus.rd_en && bus.rd_addr == 2) && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (waited >= 10) begin fails++; $display("FAIL abort_reach_chunk2 waited=%0d exp <10", waited); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reset_lfsr_model();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.wr_en) wr_seen++;
      if (bus.done) done_seen++;
    end
    tests++;
    if (wr_seen != 0 || done_seen != 0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL abort writes=%0d dones=%0d busy=%b exp 0/0/0", wr_seen, done_seen, bus.busy);
    end
  endtask

  task automatic test_random();
    int dcyc, dcnt, wout, w, ew;
    bit pos, clause;
    logic [LN-1:0] lits;
    logic [RW:0] st;
    int picks [7] = '{0, 1, 127, 128, 254, 255, -1};
    for (int n = 0; n < 10; n++) begin
      if (n % 3 == 1) begin
        logic [RW-1:0] sd;
        sd = RW'($urandom);
        if (n == 4) sd = RW'(3); // lane 2 hits a zero seed
        @(negedge clk);
        bus.seed = sd; bus.seed_load = 1'b1;
        @(negedge clk);
        bus.seed_load = 1'b0;
        for (int j = 0; j < LANES; j++) begin
          mlfsr[j] = sd ^ RW'(j + 1);
          if (mlfsr[j] == '0) mlfsr[j] = RW'(1);
        end
      end
      for (int i = 0; i < LN; i++) begin
        int p = picks[$urandom_range(0, 6)];
        mst[i]  = (p < 0) ? $urandom_range(0, SMAXI) : p;
        lits[i] = 1'($urandom_range(0, 1));
      end
      sync_img();
      pos = 1'($urandom_range(0, 1));
      clause = 1'($urandom_range(0, 3) != 0);
      st = 17'($urandom_range(0, 65536));
      w  = $urandom_range(0, 255) - 128;
      run_op(pos, clause, lits, st, w, 0, dcyc, dcnt, wout);
      model_op(pos, clause, lits, st);
      ew = exp_weight(pos, clause, w);
      tests++;
      if (ram_bad() != 0 || wout != ew || dcnt != 1) begin
        fails++;
        $display("FAIL rand_%0d pos=%0d cl=%0d thr=%0d bad_states=%0d weight=%0d exp %0d dones=%0d",
                 n, pos, clause, st, ram_bad(), wout, ew, dcnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_type1_inc();
    test_type2();
    test_clause0();
    test_weights();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tm_feedback_engine.md
TM_FEEDBACK_ENGINE -- requirements
Module: tm_feedback_engine

Interface
REQ-001 Parameter LITERAL_NUM, default 272: literals/TAs per clause; SHALL be an integer multiple of LANES.
REQ-002 Parameter LANES, default 16: TAs updated per cycle.
REQ-003 Parameter STATE_WIDTH, default 8: TA state width; action = state MSB (1 = include).
REQ-004 Parameter WEIGHT_WIDTH, default 8: signed clause weight width.
REQ-005 Parameter RAND_WIDTH, default 16: per-lane LFSR width.
REQ-006 Derived constant CHUNKS = LITERAL_NUM/LANES; address width AW = max(1, clog2(CHUNKS)).
REQ-007 Clock and reset SHALL be one clock and an asynchronous active-low reset: clk  in  1  clock, rising edge; rst_n  in  1  async active-low reset.
REQ-008 Ports SHALL be:
- start  in  1  request pulse
- is_positive  in  1  1 = Type I, 0 = Type II
- clause_out  in  1  clause value for this sample
- literals  in  LITERAL_NUM  sample literals
- s_thresh  in  RAND_WIDTH+1  low-probability (1/s) threshold
- weight_in  in  WEIGHT_WIDTH  signed clause weight
- seed_load  in  1  load LFSR seeds (IDLE only)
- seed  in  RAND_WIDTH  LFSR seed
- rd_en  out  1  state RAM read
- rd_addr  out  AW  chunk index
- rd_data  in  LANES*STATE_WIDTH  state chunk, valid 1 cycle after rd_en
- wr_en  out  1  state RAM write
- wr_addr  out  AW  chunk index
- wr_data  out  LANES*STATE_WIDTH  updated chunk
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- weight_out  out  WEIGHT_WIDTH  updated signed weight, valid from done until the next accepted start

Function
REQ-009 FSM SHALL have states IDLE, RUN, DRAIN, DONE: IDLE->RUN on start; RUN->DRAIN after chunk CHUNKS-1 is read; DRAIN->DONE after the last write; DONE->IDLE after one cycle.
REQ-010 On start in IDLE, the block SHALL latch is_positive, clause_out, literals, s_thresh and weight_in and assert busy from the next cycle through DONE.
REQ-011 start outside IDLE SHALL be ignored; seed_load outside IDLE SHALL be ignored.
REQ-012 RUN SHALL issue rd_en with rd_addr = 0..CHUNKS-1 on consecutive cycles.
REQ-013 For each chunk, wr_en/wr_addr/wr_data SHALL be driven in the cycle its rd_data is returned.
REQ-014 done SHALL pulse exactly CHUNKS+2 cycles after the start-accept edge.
REQ-015 Lane j SHALL own a Fibonacci LFSR seeded with seed XOR (j+1). A zero result SHALL be replaced by 1.
REQ-016 Each lane LFSR SHALL advance once per processed chunk, and lane value r SHALL be sampled before the advance.
REQ-017 The low-probability event SHALL be defined as lo = (r < s_thresh); s_thresh = 0 gives never, and s_thresh = 2^RAND_WIDTH gives always.
REQ-018 Type I, clause_out=1, literal=1: state SHALL be incremented when lo=0.
REQ-019 Type I, clause_out=1, literal=0: state SHALL be decremented when lo=1.
REQ-020 Type I, clause_out=0: state SHALL be decremented when lo=1.
REQ-021 Type II, clause_out=1, literal=0, action exclude: state SHALL be incremented deterministically.
REQ-022 All other cases: state SHALL be unchanged.
REQ-023 States SHALL saturate at 0 and 2^STATE_WIDTH-1, with no wrap.
REQ-024 Weight with clause_out=1: Type I SHALL increase magnitude by 1, with sign per weight_in (>=0 treated positive), saturating at +max/-min. Type II SHALL decrease magnitude by 1 toward 0, with 0 staying 0. clause_out=0 SHALL leave the weight unchanged.
REQ-025 Literal i SHALL map to lane i%LANES of chunk i/LANES, occupying bits [(i%LANES)*STATE_WIDTH +: STATE_WIDTH].

Reset
REQ-026 rst_n low SHALL force IDLE and clear busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data and weight_out to 0; LFSRs SHALL reset to lane value j+1.
REQ-027 Reset mid-operation SHALL abort the operation: no further writes, and no done.
REQ-028 The RAM is external and SHALL NOT be cleared by reset.

Verification
REQ-029 Reset: after rst_n low, all outputs are 0. After release with no start for 10 cycles, wr_en never asserts.
REQ-030 Type I: clause_out=1, literals all 1, s_thresh=0, all states 10 -> all states written 11. A state of 255 stays 255. done at exactly CHUNKS+2 cycles.
REQ-031 Type II: clause_out=1, literals all 0, state 127 -> 128, state 128 -> 128. With literals all 1, state 127 -> 127.
REQ-032 Type I: clause_out=0, s_thresh=65536, states 5/0 -> 4/0. With s_thresh=0, states are unchanged.
REQ-033 Weights with clause_out=1: Type I 127 -> 127; Type I -3 -> -4; Type II -3 -> -2; Type II 0 -> 0.
REQ-034 Handshake: start during busy is ignored and done pulses exactly once. rst_n pulsed at chunk 2 of 17 -> no wr_en afterwards and busy=0.
